wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between three writeback requesters: A = ALU result, B = memory load, C = link/PC+4.
- Drives the 2-bit select of the 32-bit 3:1 writeback mux.
- Drives the registered RegWrite, WriteAddr and WriteData presented to the register file.
- Arbitrates one write per cycle with a per-requester valid/ready handshake; policy is round-robin or fixed priority.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address.
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority A > B > C.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Stall  input  1  pipeline stall; suppresses all grants.
- ValidA/ValidB/ValidC  input  1 each  requester has a write pending.
- AddrA/AddrB/AddrC  input  ADDR_W each  destination register.
- DataA/DataB/DataC  input  DATA_W each  write data.
- ReadyA/ReadyB/ReadyC  output  1 each  combinational grant; transfer occurs when Valid and Ready are both 1.
- MuxSel  output  2  writeback mux select: 00 = A, 01 = B, 10 = C; 11 is never driven.
- RegWrite  output  1  registered write enable to the register file.
- WriteAddr  output  ADDR_W  registered write address.
- WriteData  output  DATA_W  registered write data.
- DroppedZero  output  1  one-cycle pulse: the granted write targeted register 0 and was suppressed.

Behaviour:
- Reset (Clk edge with Reset = 1):
  - MuxSel = 00, RegWrite = 0, WriteAddr = 0, WriteData = 0, DroppedZero = 0.
  - Priority pointer ptr = 0 (points at A).
  - Ready* are forced to 0 while Reset = 1, so no transfer occurs in a reset cycle.
  - Writes accepted before reset but not yet presented to the register file are discarded.
- Eligibility: requester i is eligible when Valid_i = 1 and Stall = 0 and Reset = 0.
- Grant, round-robin (FIXED_PRIO = 0):
  - Scan order is ptr, (ptr+1) mod 3, (ptr+2) mod 3; the first eligible requester is granted.
  - At most one Ready is high per cycle.
  - After a grant to i, ptr <= (i+1) mod 3. With no grant, ptr holds.
  - ptr only takes values 0..2.
- Grant, fixed priority (FIXED_PRIO = 1): A wins over B, B wins over C; ptr is unused and stays 0.
- Ready_i is combinational from the current-cycle Valid, Stall, Reset and ptr. It does not depend on registered outputs, so there is no path from Ready back into Valid.
- Latency: exactly 1 cycle. A grant at edge N means that after edge N+1:
  - MuxSel = i, WriteAddr = Addr_i, WriteData = Data_i.
  - RegWrite = 1, unless Addr_i = 0.
- Register-0 write: the grant is still consumed (Ready = 1) and ptr still advances. The next cycle has RegWrite = 0, DroppedZero = 1, and MuxSel/WriteAddr/WriteData updated as normal.
- No grant in a cycle: the next cycle has RegWrite = 0 and DroppedZero = 0; MuxSel, WriteAddr and WriteData hold their previous values.
- Stall = 1: all Ready = 0, ptr holds, RegWrite = 0 next cycle. Requesters must hold Valid, Addr and Data stable until granted.
- Simultaneous requests:
  - All three valid with ptr = 0 → A granted, then B, then C on consecutive cycles.
  - Full throughput is one write per cycle.
- Stall deasserting in the same cycle Valid rises: the grant occurs that cycle.
- Valid dropping without a grant is legal; there is no penalty and ptr is unchanged.

Test Plan:
- Reset, then ValidA = 1, AddrA = 5, DataA = 0xDEADBEEF for 1 cycle → ReadyA = 1 that cycle; next cycle RegWrite = 1, WriteAddr = 5, WriteData = 0xDEADBEEF, MuxSel = 00; the following cycle RegWrite = 0.
- Round-robin, A/B/C all valid and held for 6 cycles → grant order A, B, C, A, B, C; MuxSel sequence 00, 01, 10, 00, 01, 10, each lagging its grant by one cycle.
- FIXED_PRIO = 1, A and C valid for 3 cycles → ReadyA = 1 every cycle and ReadyC = 0; after A drops, C is granted on the next cycle.
- ValidB = 1, AddrB = 0, DataB = 0x12345678 → ReadyB = 1; next cycle RegWrite = 0, DroppedZero = 1, MuxSel = 01; ptr advances to C.
- ValidA = ValidC = 1 with Stall = 1 for 3 cycles → no Ready and RegWrite = 0 throughout; on the Stall = 0 cycle, the requester at ptr is granted.
- Reset asserted in the cycle after a grant to C (AddrC = 31) → after the reset edge RegWrite = 0, MuxSel = 00, ptr = 0; no write to register 31 ever appears.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: requester handshakes in, register-file write port out.
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              Stall;
    logic              ValidA, ValidB, ValidC;
    logic [ADDR_W-1:0] AddrA, AddrB, AddrC;
    logic [DATA_W-1:0] DataA, DataB, DataC;
    logic              ReadyA, ReadyB, ReadyC;
    logic [1:0]        MuxSel;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteAddr;
    logic [DATA_W-1:0] WriteData;
    logic              DroppedZero;

    modport master (
        output Stall, ValidA, ValidB, ValidC, AddrA, AddrB, AddrC, DataA, DataB, DataC,
        input  ReadyA, ReadyB, ReadyC, MuxSel, RegWrite, WriteAddr, WriteData, DroppedZero
    );

    modport slave (
        input  Stall, ValidA, ValidB, ValidC, AddrA, AddrB, AddrC, DataA, DataB, DataC,
        output ReadyA, ReadyB, ReadyC, MuxSel, RegWrite, WriteAddr, WriteData, DroppedZero
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Three-way register-file write-port arbiter (ALU / load / link) with one-cycle
// registered write presentation; round-robin or fixed A>B>C priority.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic              Clk,
    input logic              Reset,
    wb_port_arbiter_if.slave bus
);
    logic [1:0]        r_ptr;
    logic [1:0]        r_sel;
    logic              r_regwrite;
    logic              r_dropped;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic [3:0]        w_elig;
    logic [1:0]        w_ord0, w_ord1, w_ord2;
    logic [1:0]        w_sel;
    logic              w_any;
    logic [2:0]        w_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    // Bit 3 is padding so a 2-bit scan index never falls outside the vector.
    assign w_elig = {1'b0, bus.ValidC, bus.ValidB, bus.ValidA} & {4{~bus.Stall & ~Reset}};

    always_comb begin
        w_ord0 = 2'd0;
        w_ord1 = 2'd1;
        w_ord2 = 2'd2;
        if (!FIXED_PRIO) begin
            case (r_ptr)
                2'd1:    begin w_ord0 = 2'd1; w_ord1 = 2'd2; w_ord2 = 2'd0; end
                2'd2:    begin w_ord0 = 2'd2; w_ord1 = 2'd0; w_ord2 = 2'd1; end
                default: ;
            endcase
        end
        w_any = 1'b1;
        w_sel = w_ord0;
        if (w_elig[w_ord0])      w_sel = w_ord0;
        else if (w_elig[w_ord1]) w_sel = w_ord1;
        else if (w_elig[w_ord2]) w_sel = w_ord2;
        else begin
            w_any = 1'b0;
            w_sel = 2'd0;
        end
    end

    assign w_gnt = w_any ? (3'b001 << w_sel) : 3'b000;

    always_comb begin
        case (w_sel)
            2'd1:    begin w_addr = bus.AddrB; w_data = bus.DataB; end
            2'd2:    begin w_addr = bus.AddrC; w_data = bus.DataC; end
            default: begin w_addr = bus.AddrA; w_data = bus.DataA; end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ptr      <= 2'd0;
            r_sel      <= 2'd0;
            r_regwrite <= 1'b0;
            r_dropped  <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_regwrite <= w_any && (w_addr != '0);
            r_dropped  <= w_any && (w_addr == '0);
            if (w_any) begin
                r_sel  <= w_sel;
                r_addr <= w_addr;
                r_data <= w_data;
                if (!FIXED_PRIO) r_ptr <= (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
            end
        end
    end

    assign bus.ReadyA      = w_gnt[0];
    assign bus.ReadyB      = w_gnt[1];
    assign bus.ReadyC      = w_gnt[2];
    assign bus.MuxSel      = r_sel;
    // A write still waiting to commit is discarded if the commit edge is a reset edge.
    assign bus.RegWrite    = r_regwrite & ~Reset;
    assign bus.WriteAddr   = r_addr;
    assign bus.WriteData   = r_data;
    assign bus.DroppedZero = r_dropped;
endmodule
